vector_sum: RTL and testbench

Sequential signed reduction of a packed vector to one scalar. It is the consumer for the element-wise vector stage's `result`/`result_valid`/`result_ready` port: it accepts a whole vector on a valid/ready handshake and accumulates TILING cells per cycle. It returns the scalar sum with an overflow flag on a second valid/ready handshake. Fixed-point format is unchanged: input cells and result share FRACTION_WIDTH, so there is no shift.

---
 rtl/vector_sum_pkg.sv | 20 ++
 rtl/vector_sum_sat_narrow.sv | 31 +++
 rtl/vector_sum.sv | 117 +++++++++++
 tb/tb_vector_sum.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vector_sum_pkg.sv
// rtl/vector_sum_pkg.sv - shared state encodings and width helper for vector_sum
package vector_sum_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vector_sum_sat_narrow.sv
// rtl/vector_sum_sat_narrow.sv - accumulator narrowing with overflow flag (VECTOR_SUM_SATURATE_EN selects clamp vs wrap)
module sat_narrow #(
  parameter int IN_WIDTH  = 12,
  parameter int OUT_WIDTH = 8
) (
  input  logic signed [IN_WIDTH-1:0]  acc,
  output logic        [OUT_WIDTH-1:0] result,
  output logic                        overflow
);

  generate
    if (OUT_WIDTH >= IN_WIDTH) begin : g_extend
      // Every accumulator value fits: plain sign extension, never overflows.
      assign result   = OUT_WIDTH'(acc);
      assign overflow = 1'b0;
    end else begin : g_narrow
      // The value fits only when all bits from the output sign bit upward agree.
      logic [IN_WIDTH-OUT_WIDTH:0] top_bits;
      assign top_bits = acc[IN_WIDTH-1:OUT_WIDTH-1];
      assign overflow = !((&top_bits) || !(|top_bits));
`ifdef VECTOR_SUM_SATURATE_EN
      assign result = !overflow        ? acc[OUT_WIDTH-1:0] :
                      acc[IN_WIDTH-1]  ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                         {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
      assign result = acc[OUT_WIDTH-1:0];
`endif
    end
  endgenerate

endmodule

// File: rtl/vector_sum.sv
// rtl/vector_sum.sv - sequential signed reduction of a packed vector (option: VECTOR_SUM_SATURATE_EN)
module vector_sum
  import vector_sum_pkg::*;
#(
  parameter int VECTOR_LEN   = 5,
  parameter int CELL_WIDTH   = 8,
  parameter int RESULT_WIDTH = 8,
  parameter int TILING       = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [VECTOR_LEN*CELL_WIDTH-1:0] vector,
  input  logic                           vector_valid,
  output logic                           vector_ready,
  output logic [RESULT_WIDTH-1:0]        result,
  output logic                           result_valid,
  input  logic                           result_ready,
  output logic                           error
);

  localparam int ACC_WIDTH = CELL_WIDTH + log2_ceil(VECTOR_LEN) + 1;
  localparam int CNT_W     = log2_ceil(VECTOR_LEN) + 1;

  state_e                           state_q, state_d;
  logic [VECTOR_LEN*CELL_WIDTH-1:0] buf_q, buf_d;
  logic signed [ACC_WIDTH-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [RESULT_WIDTH-1:0]          result_q, result_d;
  logic                             error_q, error_d;

  logic signed [ACC_WIDTH-1:0]      lane_sum;
  logic signed [ACC_WIDTH-1:0]      acc_next;
  logic [CNT_W-1:0]                 cnt_end;
  logic [RESULT_WIDTH-1:0]          narrow_result;
  logic                             narrow_overflow;

  // Sum the cells whose index falls in [cnt, cnt+TILING); lanes past the vector end contribute nothing.
  always_comb begin
    lane_sum = '0;
    cnt_end  = cnt_q + CNT_W'(TILING);
    for (int i = 0; i < VECTOR_LEN; i++) begin
      if ((CNT_W'(i) >= cnt_q) && (CNT_W'(i) < cnt_end)) begin
        lane_sum = lane_sum + ACC_WIDTH'($signed(buf_q[i*CELL_WIDTH +: CELL_WIDTH]));
      end
    end
    acc_next = acc_q + lane_sum;
  end

  sat_narrow #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (RESULT_WIDTH)
  ) u_sat_narrow (
    .acc      (acc_next),
    .result   (narrow_result),
    .overflow (narrow_overflow)
  );

  // Next-state and datapath control; result/error only load on the step into DONE.
  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    error_d  = error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (vector_valid) begin
          buf_d   = vector;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_d = acc_next;
        cnt_d = cnt_end;
        if (cnt_end >= CNT_W'(VECTOR_LEN)) begin
          result_d = narrow_result;
          error_d  = narrow_overflow;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      buf_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign vector_ready = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_DONE);
  assign result       = result_q;
  assign error        = error_q;

endmodule

// File: tb/tb_vector_sum.sv
// tb/tb_vector_sum.sv - directed self-checking bench for vector_sum (wrap or VECTOR_SUM_SATURATE_EN build)
module tb_vector_sum;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [39:0] vector = '0;
  logic        vector_valid = 1'b0;
  logic        vector_ready;
  logic [7:0]  result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic        error;

  logic [39:0] vector2 = '0;
  logic        vector_valid2 = 1'b0;
  logic        vector_ready2;
  logic [7:0]  result2;
  logic        result_valid2;
  logic        result_ready2 = 1'b0;
  logic        error2;

  int checks = 0;
  int errors = 0;
  int cyc;

  always #5 clk = ~clk;

  vector_sum #(.VECTOR_LEN(5), .CELL_WIDTH(8), .RESULT_WIDTH(8), .TILING(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .vector       (vector),
    .vector_valid (vector_valid),
    .vector_ready (vector_ready),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .error        (error)
  );

  vector_sum #(.VECTOR_LEN(5), .CELL_WIDTH(8), .RESULT_WIDTH(8), .TILING(2)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .vector       (vector2),
    .vector_valid (vector_valid2),
    .vector_ready (vector_ready2),
    .result       (result2),
    .result_valid (result_valid2),
    .result_ready (result_ready2),
    .error        (error2)
  );

  function automatic logic [39:0] pk(input int c0, input int c1, input int c2, input int c3, input int c4);
    logic [7:0] b0, b1, b2, b3, b4;
    b0 = 8'(c0); b1 = 8'(c1); b2 = 8'(c2); b3 = 8'(c3); b4 = 8'(c4);
    return {b4, b3, b2, b1, b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a vector for one edge (E0), then count edges until result_valid.
  task automatic send_and_wait(input logic [39:0] v, output int edges);
    vector = v;
    vector_valid = 1'b1;
    step();
    vector_valid = 1'b0;
    edges = 0;
    while (!result_valid && edges < 20) begin
      step();
      edges++;
    end
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk({tag, "_ready_after"}, {31'b0, vector_ready}, 32'd1);
  endtask

  task automatic run_vec(input string tag, input logic [39:0] v, input logic [7:0] exp_res, input logic exp_err);
    int edges;
    send_and_wait(v, edges);
    chk({tag, "_latency"}, edges, 32'd5);
    chk({tag, "_result"}, {24'b0, result}, {24'b0, exp_res});
    chk({tag, "_error"}, {31'b0, error}, {31'b0, exp_err});
    handshake(tag);
  endtask

  initial begin
    #2;
    chk("rst_ready", {31'b0, vector_ready}, 32'd1);
    chk("rst_valid", {31'b0, result_valid}, 32'd0);
    chk("rst_result", {24'b0, result}, 32'd0);
    chk("rst_error", {31'b0, error}, 32'd0);
    chk("rst_ready2", {31'b0, vector_ready2}, 32'd1);
    step();
    rst = 1'b1;
    step();

    run_vec("basic", pk(1, 2, 3, 4, 5), 8'd15, 1'b0);
    run_vec("max_fit", pk(120, 7, 0, 0, 0), 8'd127, 1'b0);
    run_vec("neg_small", pk(-1, -1, -1, -1, -1), 8'hFB, 1'b0);
`ifdef VECTOR_SUM_SATURATE_EN
    run_vec("pos_ovf", pk(100, 100, 0, 0, 0), 8'd127, 1'b1);
    run_vec("neg_ovf", pk(-128, -128, 0, 0, 0), 8'h80, 1'b1);
`else
    run_vec("pos_ovf", pk(100, 100, 0, 0, 0), 8'hC8, 1'b1);
    run_vec("neg_ovf", pk(-128, -128, 0, 0, 0), 8'h00, 1'b1);
`endif

    // Backpressure: result held, new vector not taken until after the handshake.
    send_and_wait(pk(10, 20, 30, -5, -5), cyc);
    chk("bp_latency", cyc, 32'd5);
    vector = pk(2, 2, 2, 2, 2);
    vector_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_result", {24'b0, result}, 32'h32);
      chk("bp_valid", {31'b0, result_valid}, 32'd1);
      chk("bp_vready", {31'b0, vector_ready}, 32'd0);
    end
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
    chk("bp_ed_vready", {31'b0, vector_ready}, 32'd1);
    chk("bp_ed_valid", {31'b0, result_valid}, 32'd0);
    step();
    vector_valid = 1'b0;
    chk("bp_accepted", {31'b0, vector_ready}, 32'd0);
    cyc = 0;
    while (!result_valid && cyc < 20) begin
      step();
      cyc++;
    end
    chk("bp2_latency", cyc, 32'd5);
    chk("bp2_result", {24'b0, result}, 32'd10);
    handshake("bp2");

    // TILING=2 instance: three calc edges, out-of-range lane adds zero.
    vector2 = pk(1, -1, 2, -2, 7);
    vector_valid2 = 1'b1;
    step();
    vector_valid2 = 1'b0;
    cyc = 0;
    while (!result_valid2 && cyc < 20) begin
      step();
      cyc++;
    end
    chk("tile2_latency", cyc, 32'd3);
    chk("tile2_result", {24'b0, result2}, 32'd7);
    chk("tile2_error", {31'b0, error2}, 32'd0);
    result_ready2 = 1'b1;
    step();
    result_ready2 = 1'b0;
    chk("tile2_ready_after", {31'b0, vector_ready2}, 32'd1);

    // Asynchronous reset in the middle of CALC.
    vector = pk(1, 1, 1, 1, 1);
    vector_valid = 1'b1;
    step();
    vector_valid = 1'b0;
    step();
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {31'b0, result_valid}, 32'd0);
    chk("mid_rst_result", {24'b0, result}, 32'd0);
    chk("mid_rst_error", {31'b0, error}, 32'd0);
    chk("mid_rst_ready", {31'b0, vector_ready}, 32'd1);
    step();
    rst = 1'b1;
    step();
    run_vec("post_rst", pk(5, 5, 5, 5, 5), 8'd25, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
